// File: rtl/gpr_wb_arbiter.sv
// GPR write-port arbiter: execute path vs. load return, with a load scoreboard and starvation guard.
// Optional statistics counter enabled by defining GPR_WB_STATS_EN.

`ifndef GPR_WRITE_ALU
`define GPR_WRITE_ALU 2'd0
`endif
`ifndef GPR_WRITE_MEM
`define GPR_WRITE_MEM 2'd1
`endif
`ifndef GPR_WRITE_PC
`define GPR_WRITE_PC 2'd2
`endif

module gpr_wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_dst,
    input  logic        alu_link,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_dst,
    input  logic        ld_issue,
    input  logic [4:0]  ld_issue_dst,
    output logic        gpr_we,
    output logic [4:0]  gpr_waddr,
    output logic [1:0]  gpr_wsel,
    output logic [31:0] pending,
    output logic [15:0] conflict_cnt
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_ALU,
        GRANT_MEM
    } grant_t;

    grant_t            grant;
    logic              alu_hz;
    logic              alu_ok;
    logic [CNT_W-1:0]  wait_cnt;
    logic [31:0]       pending_next;

    assign alu_hz = pending[alu_dst] && (alu_dst != 5'd0);
    assign alu_ok = alu_valid && !alu_hz;

    // Memory normally wins; the execute path jumps ahead once it has waited STARVE_LIMIT cycles.
    always_comb begin
        grant = GRANT_NONE;
        if (!rst_n)
            grant = GRANT_NONE;
        else if (mem_valid && alu_ok && (wait_cnt == LIMIT))
            grant = GRANT_ALU;
        else if (mem_valid)
            grant = GRANT_MEM;
        else if (alu_ok)
            grant = GRANT_ALU;
    end

    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        gpr_we    = 1'b0;
        gpr_waddr = 5'd0;
        gpr_wsel  = `GPR_WRITE_ALU;
        case (grant)
            GRANT_ALU: begin
                alu_ready = 1'b1;
                gpr_we    = (alu_dst != 5'd0);
                gpr_waddr = alu_dst;
                gpr_wsel  = alu_link ? `GPR_WRITE_PC : `GPR_WRITE_ALU;
            end
            GRANT_MEM: begin
                mem_ready = 1'b1;
                gpr_we    = (mem_dst != 5'd0);
                gpr_waddr = mem_dst;
                gpr_wsel  = `GPR_WRITE_MEM;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            wait_cnt <= '0;
        else if (grant == GRANT_ALU)
            wait_cnt <= '0;
        else if (alu_ok && (grant == GRANT_MEM) && (wait_cnt != LIMIT))
            wait_cnt <= wait_cnt + CNT_W'(1);
    end

    // A load issued in the same cycle as a return to that register is a new outstanding load, so set wins.
    always_comb begin
        pending_next = pending;
        if (grant == GRANT_MEM)
            pending_next[mem_dst] = 1'b0;
        if (ld_issue && (ld_issue_dst != 5'd0))
            pending_next[ld_issue_dst] = 1'b1;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            pending <= '0;
        else
            pending <= pending_next;
    end

`ifdef GPR_WB_STATS_EN
    logic [15:0] conflict_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            conflict_q <= '0;
        else if (alu_valid && !alu_ready && (conflict_q != 16'hFFFF))
            conflict_q <= conflict_q + 16'd1;
    end

    assign conflict_cnt = conflict_q;
`else
    assign conflict_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Self-checking bench for gpr_wb_arbiter: scoreboard of expected grant outputs and scoreboard state per cycle.
// Build with GPR_WB_STATS_EN defined to also check the stall counter.

`ifndef GPR_WRITE_ALU
`define GPR_WRITE_ALU 2'd0
`endif
`ifndef GPR_WRITE_MEM
`define GPR_WRITE_MEM 2'd1
`endif
`ifndef GPR_WRITE_PC
`define GPR_WRITE_PC 2'd2
`endif

module tb_gpr_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_dst;
    logic        alu_link;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_dst;
    logic        ld_issue;
    logic [4:0]  ld_issue_dst;
    logic        gpr_we;
    logic [4:0]  gpr_waddr;
    logic [1:0]  gpr_wsel;
    logic [31:0] pending;
    logic [15:0] conflict_cnt;

    int checks = 0;
    int fails  = 0;

    typedef struct packed {
        logic        rn;
        logic        av;
        logic [4:0]  ad;
        logic        al;
        logic        mv;
        logic [4:0]  md;
        logic        li;
        logic [4:0]  lid;
    } stim_t;

    typedef struct packed {
        logic        ar;
        logic        mr;
        logic        we;
        logic [4:0]  waddr;
        logic [1:0]  wsel;
        logic [31:0] pend;
    } obs_t;

    obs_t exp_q[$];

    gpr_wb_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dst(alu_dst), .alu_link(alu_link),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dst(mem_dst),
        .ld_issue(ld_issue), .ld_issue_dst(ld_issue_dst),
        .gpr_we(gpr_we), .gpr_waddr(gpr_waddr), .gpr_wsel(gpr_wsel),
        .pending(pending), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    function automatic stim_t st(input logic rn, input logic av, input logic [4:0] ad, input logic al,
                                 input logic mv, input logic [4:0] md, input logic li, input logic [4:0] lid);
        st = '{rn, av, ad, al, mv, md, li, lid};
    endfunction

    function automatic obs_t ex(input logic ar, input logic mr, input logic we, input logic [4:0] wa,
                                input logic [1:0] ws, input logic [31:0] pd);
        ex = '{ar, mr, we, wa, ws, pd};
    endfunction

    function automatic obs_t cur_obs();
        cur_obs = '{alu_ready, mem_ready, gpr_we, gpr_waddr, gpr_wsel, pending};
    endfunction

    // Inputs change just after a rising edge; outputs are sampled at the following falling edge.
    task automatic drive(input stim_t s);
        @(posedge clk);
        #1;
        rst_n        = s.rn;
        alu_valid    = s.av;
        alu_dst      = s.ad;
        alu_link     = s.al;
        mem_valid    = s.mv;
        mem_dst      = s.md;
        ld_issue     = s.li;
        ld_issue_dst = s.lid;
        @(negedge clk);
    endtask

    task automatic test_reset;
        stim_t sq[$];
        obs_t o, e;
        drive(st(0, 1, 5'd5, 0, 1, 5'd3, 1, 5'd8));
        sq.push_back(st(0, 1, 5'd5, 1, 1, 5'd3, 1, 5'd8));
        exp_q.push_back(ex(0, 0, 0, 5'd0, `GPR_WRITE_ALU, 32'h0));
        sq.push_back(st(1, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0));
        exp_q.push_back(ex(0, 0, 0, 5'd0, `GPR_WRITE_ALU, 32'h0));
        foreach (sq[i]) begin
            drive(sq[i]);
            o = cur_obs();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                fails++;
                $display("[TB] FAIL reset step %0d: got %h expected %h", i, o, e);
            end
        end
        checks++;
        if (conflict_cnt !== 16'd0) begin
            fails++;
            $display("[TB] FAIL reset_conflict_cnt: got %0d expected 0", conflict_cnt);
        end
    endtask

    task automatic test_alu_write;
        stim_t sq[$];
        obs_t o, e;
        sq.push_back(st(1, 1, 5'd5, 0, 0, 5'd0, 0, 5'd0));
        exp_q.push_back(ex(1, 0, 1, 5'd5, `GPR_WRITE_ALU, 32'h0));
        sq.push_back(st(1, 1, 5'd6, 1, 0, 5'd0, 0, 5'd0));
        exp_q.push_back(ex(1, 0, 1, 5'd6, `GPR_WRITE_PC, 32'h0));
        foreach (sq[i]) begin
            drive(sq[i]);
            o = cur_obs();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                fails++;
                $display("[TB] FAIL alu_write step %0d: got %h expected %h", i, o, e);
            end
        end
    endtask

    task automatic test_hazard;
        stim_t sq[$];
        obs_t o, e;
        sq.push_back(st(1, 0, 5'd0, 0, 0, 5'd0, 1, 5'd7));
        exp_q.push_back(ex(0, 0, 0, 5'd0, `GPR_WRITE_ALU, 32'h0));
        sq.push_back(st(1, 1, 5'd7, 0, 0, 5'd0, 0, 5'd0));
        exp_q.push_back(ex(0, 0, 0, 5'd0, `GPR_WRITE_ALU, 32'h80));
        sq.push_back(st(1, 1, 5'd7, 0, 1, 5'd7, 0, 5'd0));
        exp_q.push_back(ex(0, 1, 1, 5'd7, `GPR_WRITE_MEM, 32'h80));
        sq.push_back(st(1, 1, 5'd7, 0, 0, 5'd0, 0, 5'd0));
        exp_q.push_back(ex(1, 0, 1, 5'd7, `GPR_WRITE_ALU, 32'h0));
        foreach (sq[i]) begin
            drive(sq[i]);
            o = cur_obs();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                fails++;
                $display("[TB] FAIL hazard step %0d: got %h expected %h", i, o, e);
            end
        end
    endtask

    task automatic test_starvation;
        stim_t sq[$];
        obs_t o, e;
        for (int k = 0; k < 6; k++) begin
            sq.push_back(st(1, 1, 5'd3, 0, 1, 5'd4, 0, 5'd0));
            if (k == 4)
                exp_q.push_back(ex(1, 0, 1, 5'd3, `GPR_WRITE_ALU, 32'h0));
            else
                exp_q.push_back(ex(0, 1, 1, 5'd4, `GPR_WRITE_MEM, 32'h0));
        end
        foreach (sq[i]) begin
            drive(sq[i]);
            o = cur_obs();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                fails++;
                $display("[TB] FAIL starvation step %0d: got %h expected %h", i, o, e);
            end
        end
    endtask

    task automatic test_zero_reg;
        stim_t sq[$];
        obs_t o, e;
        sq.push_back(st(1, 1, 5'd0, 0, 0, 5'd0, 1, 5'd0));
        exp_q.push_back(ex(1, 0, 0, 5'd0, `GPR_WRITE_ALU, 32'h0));
        sq.push_back(st(1, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0));
        exp_q.push_back(ex(0, 0, 0, 5'd0, `GPR_WRITE_ALU, 32'h0));
        foreach (sq[i]) begin
            drive(sq[i]);
            o = cur_obs();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                fails++;
                $display("[TB] FAIL zero_reg step %0d: got %h expected %h", i, o, e);
            end
        end
    endtask

    // Builds up some starvation credit, resets, then proves the full wait is needed again.
    task automatic test_set_wins_and_reset;
        stim_t sq[$];
        obs_t o, e;
        sq.push_back(st(1, 1, 5'd2, 0, 1, 5'd9, 1, 5'd9));
        exp_q.push_back(ex(0, 1, 1, 5'd9, `GPR_WRITE_MEM, 32'h0));
        sq.push_back(st(1, 1, 5'd2, 0, 1, 5'd10, 0, 5'd0));
        exp_q.push_back(ex(0, 1, 1, 5'd10, `GPR_WRITE_MEM, 32'h200));
        sq.push_back(st(0, 1, 5'd2, 0, 1, 5'd10, 0, 5'd0));
        exp_q.push_back(ex(0, 0, 0, 5'd0, `GPR_WRITE_ALU, 32'h200));
        for (int k = 0; k < 6; k++) begin
            sq.push_back(st(1, 1, 5'd2, 0, 1, 5'd10, 0, 5'd0));
            if (k == 4)
                exp_q.push_back(ex(1, 0, 1, 5'd2, `GPR_WRITE_ALU, 32'h0));
            else
                exp_q.push_back(ex(0, 1, 1, 5'd10, `GPR_WRITE_MEM, 32'h0));
        end
        foreach (sq[i]) begin
            drive(sq[i]);
            o = cur_obs();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                fails++;
                $display("[TB] FAIL set_wins_reset step %0d: got %h expected %h", i, o, e);
            end
        end
    endtask

    task automatic test_stats;
        stim_t sq[$];
        obs_t o, e;
        logic [15:0] exp_cnt;
`ifdef GPR_WB_STATS_EN
        exp_cnt = 16'd3;
`else
        exp_cnt = 16'd0;
`endif
        sq.push_back(st(0, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0));
        exp_q.push_back(ex(0, 0, 0, 5'd0, `GPR_WRITE_ALU, 32'h0));
        for (int k = 0; k < 3; k++) begin
            sq.push_back(st(1, 1, 5'd11, 0, 1, 5'd12, 0, 5'd0));
            exp_q.push_back(ex(0, 1, 1, 5'd12, `GPR_WRITE_MEM, 32'h0));
        end
        sq.push_back(st(1, 0, 5'd0, 0, 0, 5'd0, 0, 5'd0));
        exp_q.push_back(ex(0, 0, 0, 5'd0, `GPR_WRITE_ALU, 32'h0));
        foreach (sq[i]) begin
            drive(sq[i]);
            o = cur_obs();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                fails++;
                $display("[TB] FAIL stats step %0d: got %h expected %h", i, o, e);
            end
        end
        checks++;
        if (conflict_cnt !== exp_cnt) begin
            fails++;
            $display("[TB] FAIL conflict_cnt: got %0d expected %0d", conflict_cnt, exp_cnt);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        alu_valid    = 1'b0;
        alu_dst      = 5'd0;
        alu_link     = 1'b0;
        mem_valid    = 1'b0;
        mem_dst      = 5'd0;
        ld_issue     = 1'b0;
        ld_issue_dst = 5'd0;
        test_reset();
        test_alu_write();
        test_hazard();
        test_starvation();
        test_zero_reg();
        test_set_wins_and_reset();
        test_stats();
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/gpr_wb_arbiter.md
Name: gpr_wb_arbiter

Overview:
- Owns the single GPR write port and drives the select of the GPR write-data mux (`GPR_WRITE_ALU / `GPR_WRITE_MEM / `GPR_WRITE_PC from defines.v).
- Arbitrates between two requesters: the execute path (ALU result or link PC+4) and the variable-latency load-return path.
- Keeps a load scoreboard so a younger ALU write cannot overtake an outstanding load to the same register.
- Starvation guard: execute path is granted after a bounded wait.

Parameters:
STARVE_LIMIT, 4, consecutive blocked-by-memory cycles after which the execute path gets priority for one grant (1..15)
CNT_W, 4, width of the starvation counter; must hold STARVE_LIMIT

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous reset, active low
alu_valid  in  1  execute path has a write pending
alu_ready  out  1  execute write accepted this cycle
alu_dst  in  5  execute destination register
alu_link  in  1  1 = write PC+4 (`GPR_WRITE_PC), 0 = ALU result (`GPR_WRITE_ALU)
mem_valid  in  1  load data returning
mem_ready  out  1  load write accepted this cycle
mem_dst  in  5  load destination register
ld_issue  in  1  a load is issued this cycle
ld_issue_dst  in  5  destination of the issued load
gpr_we  out  1  GPR write enable
gpr_waddr  out  5  GPR write address
gpr_wsel  out  2  write-data mux select
pending  out  32  scoreboard, bit n = load outstanding to register n
conflict_cnt  out  16  stats counter (only with the optional feature, else tied 0)

Behaviour:
- Reset (rst_n low at a rising edge): pending=0, wait_cnt=0, conflict_cnt=0.
  - gpr_we=0, gpr_waddr=0, gpr_wsel=`GPR_WRITE_ALU, alu_ready=0, mem_ready=0 while rst_n is low.
  - A request in flight during reset is dropped; requesters re-present it after reset.
- Handshake: a transfer occurs in the cycle where valid&&ready.
  - The GPR write happens at the rising edge that ends that cycle.
  - gpr_we/waddr/wsel are combinational from the grant: zero-latency, one write per cycle max.
  - valid must hold with stable dst until ready.
- Hazard: alu_hz = pending[alu_dst] && alu_dst!=0. An ALU request with alu_hz is never granted; it stalls.
- Arbitration, evaluated each cycle:
  - mem_valid && alu_valid && !alu_hz && wait_cnt==STARVE_LIMIT: grant ALU, mem_ready=0.
  - else if mem_valid: grant MEM.
  - else if alu_valid && !alu_hz: grant ALU.
  - else no grant, gpr_we=0.
- Grant outputs:
  - ALU grant: gpr_wsel = alu_link ? `GPR_WRITE_PC : `GPR_WRITE_ALU, gpr_waddr = alu_dst.
  - MEM grant: gpr_wsel = `GPR_WRITE_MEM, gpr_waddr = mem_dst.
- Register 0: the handshake completes normally but gpr_we=0.
- wait_cnt update:
  - Increments (saturating at STARVE_LIMIT) in cycles where the ALU is blocked only by a MEM grant.
  - Clears on every ALU grant.
  - Holds in cycles with no alu_valid or with alu_hz.
- Scoreboard update at each edge:
  - A MEM transfer clears pending[mem_dst].
  - ld_issue sets pending[ld_issue_dst].
  - Same register set and cleared in the same cycle: set wins.
  - ld_issue_dst=0 is ignored; pending[0] is always 0.
- A MEM return to a non-pending register is still written; no error is raised.

Optional Feature:
- Macro GPR_WB_STATS_EN.
- When defined: conflict_cnt increments by 1, saturating at 16'hFFFF, in every cycle where alu_valid && !alu_ready, whether the stall comes from the hazard or from memory. Cleared by reset.
- When undefined: conflict_cnt is constant 0 and no counter logic is built.

Test Plan:
- alu_valid=1, alu_dst=5, alu_link=0, no mem -> same cycle alu_ready=1, gpr_we=1, gpr_waddr=5, gpr_wsel=`GPR_WRITE_ALU; with alu_link=1 -> gpr_wsel=`GPR_WRITE_PC.
- ld_issue, dst=7; next cycle alu_valid, dst=7 -> alu_ready=0, pending[7]=1; mem_valid, dst=7 -> mem write at reg 7 with `GPR_WRITE_MEM; following cycle the ALU is granted, pending[7]=0.
- mem_valid and alu_valid held high, distinct dsts, STARVE_LIMIT=4 -> MEM granted 4 cycles, ALU granted on the 5th with mem_ready=0, then MEM resumes.
- alu_dst=0 valid -> alu_ready=1, gpr_we=0; ld_issue_dst=0 -> pending stays 0.
- ld_issue dst=9 in the same cycle as a MEM transfer to 9 -> pending[9]=1 afterwards; then rst_n=0 for 1 cycle -> pending=0, gpr_we=0, wait_cnt=0.
- With GPR_WB_STATS_EN: ALU stalled 3 cycles -> conflict_cnt=3; without the macro -> conflict_cnt=0.
